serial_add_sched: RTL and testbench

SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

---
 rtl/serial_add_sched.sv | 122 ++++++++++++
 tb/tb_serial_add_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sched.sv
// serial_add_sched
//   Two-requester bit-serial adder. A round-robin arbiter in IDLE accepts one
//   request, loads its operands into shift registers, then adds one bit per
//   cycle (LSB first) for WIDTH cycles. The result is presented in a single
//   DONE cycle and held on sum/cout/done_id until the next completion.
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   req0/a0/b0     requester 0 level request and operands
//   req1/a1/b1     requester 1 level request and operands
//   gnt0/gnt1      one-cycle acceptance pulse (operands sampled on this edge)
//   busy           high while an add is in RUN or DONE
//   sum/cout       registered result and carry of the last completed add
//   done           one-cycle completion pulse
//   done_id        requester index of the last completed add
module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done,
  output logic             done_id
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             owner;
  logic             rr_ptr;   // port favoured on a tie
  logic [1:0]       add_p0;   // {carry out, sum bit} of the current bit

  // Two cascaded half-add stages: {c1 | (s1 & c), s1 ^ c}.
  function automatic logic [1:0] bit_add(input logic a, input logic b, input logic c);
    logic s1, c1;
    s1 = a ^ b;
    c1 = a & b;
    return {c1 | (s1 & c), s1 ^ c};
  endfunction

  assign add_p0 = bit_add(a_sr[0], b_sr[0], carry);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grants are combinational in IDLE; gated by rst_n so they drop the moment
  // reset asserts even while a request is held.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (req0 || req1)) begin
          if (req0 && (!req1 || !rr_ptr)) gnt0 = 1'b1;
          else                             gnt1 = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      owner   <= 1'b0;
      rr_ptr  <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      done_id <= 1'b0;
    end else if (gnt0 || gnt1) begin
      a_sr   <= gnt1 ? a1 : a0;
      b_sr   <= gnt1 ? b1 : b0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      owner  <= gnt1;
      rr_ptr <= gnt0;   // next tie goes to the other port
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {add_p0[0], res_sr[WIDTH-1:1]};
      carry  <= add_p0[1];
      cnt    <= cnt + 1'b1;
      // Last bit: the final sum bit enters at the MSB as the word is loaded.
      if (cnt == LAST) begin
        sum     <= {add_p0[0], res_sr[WIDTH-1:1]};
        cout    <= add_p0[1];
        done_id <= owner;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sched.sv
module tb_serial_add_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, busy, cout, done, done_id;
  logic [W-1:0] sum;

  int vectors     = 0;
  int miscompares = 0;

  serial_add_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .sum(sum), .cout(cout), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  vec_t tbl[7];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic set_req(input logic port, input logic [W-1:0] a, input logic [W-1:0] b);
    if (port == 1'b0) begin req0 = 1'b1; a0 = a; b0 = b; end
    else              begin req1 = 1'b1; a1 = a; b1 = b; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Called at negedge+1 with requests already driven; bounded wait for a grant.
  task automatic wait_gnt(input logic exp_port, input string nm);
    int n = 0;
    while (!(gnt0 || gnt1) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, "_gnt0"}, gnt0, exp_port == 1'b0);
    chk({nm, "_gnt1"}, gnt1, exp_port == 1'b1);
  endtask

  // Follows an add from the cycle after its grant through DONE and the next
  // IDLE cycle. Optionally raises req1 or pulses req0 while busy.
  task automatic finish_add(input logic [W-1:0] es, input logic ec, input logic did,
                            input string nm, input int raise1_at, input int pulse0_at);
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin req0 = 1'b0; req1 = 1'b0; end
      if (k == raise1_at) req1 = 1'b1;
      if (k == pulse0_at) req0 = 1'b1;
      if (pulse0_at != 0 && k == pulse0_at + 1) req0 = 1'b0;
      #1;
      chk({nm, "_busy"}, busy, 1'b1);
      chk({nm, "_done"}, done, k == W + 1);
      chk({nm, "_nogrant"}, {gnt0, gnt1}, 2'b00);
      if (k == W + 1) begin
        chk({nm, "_sum"},  sum,     es);
        chk({nm, "_cout"}, cout,    ec);
        chk({nm, "_id"},   done_id, did);
      end
    end
    @(negedge clk); #1;
    chk({nm, "_idle_busy"}, busy, 1'b0);
    chk({nm, "_idle_done"}, done, 1'b0);
  endtask

  initial begin
    logic [W:0] full;
    logic [W-1:0] ra, rb, rx, ry;
    logic pref, winner;
    int sel;
    int gq[$];

    tbl[0] = '{1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0};
    tbl[1] = '{1'b1, 8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[2] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
    tbl[3] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[4] = '{1'b0, 8'h55, 8'hAA, 8'hFF, 1'b0};
    tbl[5] = '{1'b1, 8'hFF, 8'hFF, 8'hFE, 1'b1};
    tbl[6] = '{1'b0, 8'h01, 8'h7F, 8'h80, 1'b0};

    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    a0 = 8'hAA; b0 = 8'h55; a1 = 8'h11; b1 = 8'h22;
    #1;
    chk("rst_gnt",  {gnt0, gnt1}, 2'b00);
    chk("rst_busy", busy,    1'b0);
    chk("rst_done", done,    1'b0);
    chk("rst_sum",  sum,     8'h00);
    chk("rst_cout", cout,    1'b0);
    chk("rst_id",   done_id, 1'b0);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      set_req(tbl[i].port, tbl[i].a, tbl[i].b);
      #1;
      wait_gnt(tbl[i].port, $sformatf("tbl%0d", i));
      finish_add(tbl[i].es, tbl[i].ec, tbl[i].port, $sformatf("tbl%0d", i), 0, 0);
    end

    // req1 raised mid-RUN: held off until the IDLE cycle after done.
    set_req(1'b0, 8'h12, 8'h34);
    a1 = 8'hF0; b1 = 8'h0F;
    #1;
    wait_gnt(1'b0, "hold");
    finish_add(8'h46, 1'b0, 1'b0, "hold_p0", 3, 0);
    chk("hold_gnt1_after_done", gnt1, 1'b1);
    chk("hold_gnt0_after_done", gnt0, 1'b0);
    finish_add(8'hFF, 1'b0, 1'b1, "hold_p1", 0, 0);

    // req0 pulsed while busy and gone by IDLE: no grant, results held.
    set_req(1'b1, 8'h20, 8'h22);
    #1;
    wait_gnt(1'b1, "pulse");
    finish_add(8'h42, 1'b0, 1'b1, "pulse", 0, 3);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      chk("pulse_gnt0", gnt0, 1'b0);
      chk("pulse_done", done, 1'b0);
      chk("pulse_sum",  sum,  8'h42);
    end

    // Reset at RUN bit 4 aborts with no done; after release port 0 wins a tie.
    set_req(1'b0, 8'h3C, 8'h0F);
    #1;
    wait_gnt(1'b0, "abort");
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req0 = 1'b0;
      #1;
      chk("abort_done_pre", done, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy,    1'b0);
    chk("abort_done", done,    1'b0);
    chk("abort_sum",  sum,     8'h00);
    chk("abort_cout", cout,    1'b0);
    chk("abort_id",   done_id, 1'b0);
    chk("abort_gnt",  {gnt0, gnt1}, 2'b00);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      #1;
      chk("abort_nodone", done, 1'b0);
    end
    set_req(1'b0, 8'h11, 8'h22);
    set_req(1'b1, 8'h33, 8'h44);
    #1;
    wait_gnt(1'b0, "abort_tie");
    finish_add(8'h33, 1'b0, 1'b0, "abort_tie", 0, 0);

    // Both requests held continuously after reset.
    do_reset();
    set_req(1'b0, 8'h01, 8'h02);
    set_req(1'b1, 8'h03, 8'h04);
    #1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (gnt0) gq.push_back(cyc * 2);
      if (gnt1) gq.push_back(cyc * 2 + 1);
      @(negedge clk);
      if (cyc == 39) begin req0 = 1'b0; req1 = 1'b0; end
      #1;
    end
    chk("rr_count", gq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), (i < gq.size()) ? gq[i] : -1, i * 20 + (i % 2));
    chk("rr_last_sum", sum, 8'h07);

    // Randomized requests against an arbitration/arithmetic model.
    do_reset();
    pref = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(1, 3);
      ra = W'($urandom); rb = W'($urandom);
      rx = W'($urandom); ry = W'($urandom);
      if (sel[0]) set_req(1'b0, ra, rb);
      if (sel[1]) set_req(1'b1, rx, ry);
      winner = (sel == 3) ? pref : (sel == 2);
      full = winner ? ({1'b0, rx} + {1'b0, ry}) : ({1'b0, ra} + {1'b0, rb});
      #1;
      wait_gnt(winner, $sformatf("rnd%0d", i));
      pref = ~winner;
      finish_add(full[W-1:0], full[W], winner, $sformatf("rnd%0d", i), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
